// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM states, index
// width helper and the read value returned when an access is aborted.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] ABORT_RDATA = '1;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker over ports 1..NUM_PORTS-1; port 0 is
// never considered here, its priority is applied by the arbiter.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Walk from the farthest candidate to the nearest so the nearest port
    // after 'last' overwrites and wins; wrap skips port 0.
    for (int k = NUM_PORTS - 1; k >= 1; k--) begin
      cand = int'(last) + k;
      if (cand >= NUM_PORTS) cand = cand - (NUM_PORTS - 1);
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        idx   = cand_idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Single-transaction SDRAM arbiter: port 0 has fixed priority, other ports
// share round-robin; a watchdog aborts accesses the controller never finishes.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  input  logic [NUM_PORTS*2-1:0]      p_be,
  output logic [NUM_PORTS-1:0]        p_ack,
  output logic [DATA_W-1:0]           p_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [1:0]                  mem_be,
  input  logic                        mem_gnt,
  input  logic                        mem_done,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
  logic [1:0]        be_arr    [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = p_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = p_wdata[gi*DATA_W +: DATA_W];
    assign be_arr[gi]    = p_be[gi*2 +: 2];
  end

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0]  last_rr_reg, last_rr_next;
  logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [1:0]        mem_be_reg, mem_be_next;
  logic [NUM_PORTS-1:0] p_ack_reg, p_ack_next;
  logic [DATA_W-1:0] p_rdata_reg, p_rdata_next;
  logic              timeout_err_reg, timeout_err_next;

  logic [IDX_W-1:0]  rr_idx, win_idx;
  logic              rr_valid, win_valid;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req   (p_req),
    .last  (last_rr_reg),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  assign win_idx   = p_req[0] ? '0 : rr_idx;
  assign win_valid = p_req[0] | rr_valid;

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_rr_next     = last_rr_reg;
    wd_cnt_next      = wd_cnt_reg;
    mem_req_next     = mem_req_reg;
    mem_we_next      = mem_we_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    mem_be_next      = mem_be_reg;
    p_ack_next       = '0;
    p_rdata_next     = p_rdata_reg;
    timeout_err_next = timeout_err_reg;
    unique case (state_reg)
      IDLE: begin
        if (win_valid) begin
          grant_next     = win_idx;
          mem_req_next   = 1'b1;
          mem_we_next    = p_we[win_idx];
          mem_addr_next  = addr_arr[win_idx];
          mem_wdata_next = wdata_arr[win_idx];
          mem_be_next    = be_arr[win_idx];
          if (win_idx != '0) last_rr_next = win_idx;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          mem_req_next = 1'b0;
          wd_cnt_next  = '0;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        // wd_cnt_reg counts completed WAIT cycles, so this is WAIT cycle TIMEOUT.
        if (mem_done) begin
          p_rdata_next          = mem_rdata;
          p_ack_next[grant_reg] = 1'b1;
          state_next            = DONE;
        end else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
          p_rdata_next          = ABORT_RDATA[DATA_W-1:0];
          p_ack_next[grant_reg] = 1'b1;
          timeout_err_next      = 1'b1;
          state_next            = DONE;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      last_rr_reg     <= '0;
      wd_cnt_reg      <= '0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_be_reg      <= '0;
      p_ack_reg       <= '0;
      p_rdata_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_rr_reg     <= last_rr_next;
      wd_cnt_reg      <= wd_cnt_next;
      mem_req_reg     <= mem_req_next;
      mem_we_reg      <= mem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      mem_be_reg      <= mem_be_next;
      p_ack_reg       <= p_ack_next;
      p_rdata_reg     <= p_rdata_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign p_ack       = p_ack_reg;
  assign p_rdata     = p_rdata_reg;
  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign mem_be      = mem_be_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a scripted controller serves each
// request and every test task compares outputs against hand-computed values.
module tb_sdram_port_arbiter;

  logic        clk_sys;
  logic        reset;
  logic [2:0]  p_req, p_we;
  logic [71:0] p_addr;
  logic [47:0] p_wdata;
  logic [5:0]  p_be;
  logic [2:0]  p_ack;
  logic [15:0] p_rdata;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_gnt, mem_done;
  logic [15:0] mem_rdata;
  logic        busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  sdram_port_arbiter #(
    .NUM_PORTS (3),
    .ADDR_W    (24),
    .DATA_W    (16),
    .TIMEOUT   (255)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .p_req       (p_req),
    .p_we        (p_we),
    .p_addr      (p_addr),
    .p_wdata     (p_wdata),
    .p_be        (p_be),
    .p_ack       (p_ack),
    .p_rdata     (p_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_gnt     (mem_gnt),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  function automatic int ack_port(input logic [2:0] a);
    case (a)
      3'b000:  return -1;
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -9;
    endcase
  endfunction

  task automatic set_port(input int port, input logic we, input logic [23:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be);
    p_we[port]             = we;
    p_addr[port*24 +: 24]  = addr;
    p_wdata[port*16 +: 16] = wdata;
    p_be[port*2 +: 2]      = be;
  endtask

  task automatic do_reset();
    reset = 1'b1; p_req = '0; mem_gnt = 1'b0; mem_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Scripted controller: waits for mem_req, grants after gnt_dly cycles,
  // completes after done_dly WAIT cycles, returns at the IDLE cycle after the ack.
  task automatic serve(input int gnt_dly, input int done_dly, input logic [15:0] rd,
                       input logic early, output int grant, output logic [15:0] rdata_o,
                       output logic [23:0] addr_o, output logic we_o,
                       output logic [15:0] wdata_o, output logic [1:0] be_o,
                       output int req_wait, output logic req_after_gnt,
                       output int stray, output logic [2:0] ack_after);
    int n;
    grant = -2; rdata_o = '0; addr_o = '0; we_o = 1'b0; wdata_o = '0; be_o = '0;
    req_after_gnt = 1'b1; stray = 0; ack_after = 3'b111; n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      if (p_ack !== 3'b000) stray++;
      tick(); n++;
    end
    req_wait = n;
    if (mem_req !== 1'b1) return;
    addr_o = mem_addr; we_o = mem_we; wdata_o = mem_wdata; be_o = mem_be;
    for (int i = 0; i < gnt_dly; i++) begin
      if (p_ack !== 3'b000) stray++;
      tick();
    end
    mem_gnt = 1'b1; mem_done = early; mem_rdata = early ? 16'hDEAD : rd;
    tick();
    mem_gnt = 1'b0; mem_done = 1'b0;
    req_after_gnt = mem_req;
    for (int i = 0; i < done_dly; i++) begin
      if (p_ack !== 3'b000) stray++;
      tick();
    end
    if (p_ack !== 3'b000) stray++;
    mem_done = 1'b1; mem_rdata = rd;
    tick();
    mem_done = 1'b0;
    grant = ack_port(p_ack); rdata_o = p_rdata;
    $display("txn port=%0d addr=%h we=%0b wdata=%h be=%b rdata=%h", grant, addr_o, we_o,
             wdata_o, be_o, rdata_o);
    tick();
    ack_after = p_ack;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (p_ack !== 3'b000) begin failures++; $display("FAIL reset_p_ack got=%b exp=000", p_ack); end
    checks++; if (p_rdata !== 16'h0) begin failures++; $display("FAIL reset_p_rdata got=%h exp=0000", p_rdata); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    checks++;
    if ({mem_we, mem_addr, mem_wdata, mem_be} !== 43'h0) begin
      failures++;
      $display("FAIL reset_mem_fields got=%b/%h/%h/%b exp=0/000000/0000/00", mem_we, mem_addr, mem_wdata, mem_be);
    end
    reset = 1'b1; p_req = 3'b010;
    tick(); tick();
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_held_req got=%b%b exp=00", mem_req, busy); end
    reset = 1'b0; p_req = '0;
    tick();
  endtask

  task automatic test_single_read();
    int g, rw, st; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    do_reset();
    set_port(1, 1'b0, 24'h001234, 16'h0000, 2'b11);
    p_req = 3'b010;
    serve(1, 2, 16'hBEEF, 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
    p_req = '0;
    checks++; if (rw !== 1) begin failures++; $display("FAIL read_req_latency got=%0d exp=1", rw); end
    checks++; if (ad !== 24'h001234) begin failures++; $display("FAIL read_mem_addr got=%h exp=001234", ad); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL read_mem_we got=%b exp=0", we); end
    checks++; if (rag !== 1'b0) begin failures++; $display("FAIL read_req_after_gnt got=%b exp=0", rag); end
    checks++; if (g !== 1) begin failures++; $display("FAIL read_ack_port got=%0d exp=1", g); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL read_p_rdata got=%h exp=beef", rd); end
    checks++; if (st !== 0 || aa !== 3'b000) begin failures++; $display("FAIL read_single_pulse got=stray%0d/after%b exp=stray0/after000", st, aa); end
  endtask

  task automatic test_priority();
    int g, rw, st; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    int exp_order [6] = '{0, 0, 1, 2, 1, 2};
    do_reset();
    set_port(0, 1'b0, 24'h000100, 16'h0, 2'b11);
    set_port(1, 1'b0, 24'h000200, 16'h0, 2'b11);
    set_port(2, 1'b0, 24'h000300, 16'h0, 2'b11);
    p_req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) p_req = 3'b110;
      serve(0, 0, 16'(i), 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
      checks++;
      if (g !== exp_order[i]) begin failures++; $display("FAIL prio_grant_%0d got=%0d exp=%0d", i, g, exp_order[i]); end
      checks++;
      if (ad !== 24'(32'h100 * (exp_order[i] + 1))) begin
        failures++; $display("FAIL prio_addr_%0d got=%h exp=%h", i, ad, 24'(32'h100 * (exp_order[i] + 1)));
      end
    end
    p_req = '0;
  endtask

  task automatic test_byte_write();
    int g, rw, st; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    do_reset();
    set_port(2, 1'b1, 24'h000ABC, 16'hA500, 2'b10);
    p_req = 3'b100;
    serve(0, 1, 16'h1111, 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
    p_req = '0;
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL wr_mem_we got=%b exp=1", we); end
    checks++; if (be !== 2'b10) begin failures++; $display("FAIL wr_mem_be got=%b exp=10", be); end
    checks++; if (wd !== 16'hA500) begin failures++; $display("FAIL wr_mem_wdata got=%h exp=a500", wd); end
    checks++; if (ad !== 24'h000ABC) begin failures++; $display("FAIL wr_mem_addr got=%h exp=000abc", ad); end
    checks++; if (g !== 2 || st !== 0) begin failures++; $display("FAIL wr_ack got=port%0d/stray%0d exp=port2/stray0", g, st); end
  endtask

  task automatic test_back_to_back();
    int g, rw, st, extra; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    do_reset();
    set_port(1, 1'b0, 24'h000040, 16'h0, 2'b11);
    p_req = 3'b010;
    serve(0, 0, 16'h0001, 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
    checks++; if (g !== 1) begin failures++; $display("FAIL b2b_first_port got=%0d exp=1", g); end
    // Cycle after p_ack: port 1 presents a fresh request.
    set_port(1, 1'b0, 24'h000041, 16'h0, 2'b11);
    serve(0, 0, 16'h0002, 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
    p_req = '0;
    checks++; if (rw !== 1) begin failures++; $display("FAIL b2b_req_gap got=%0d exp=1 (2 cycles after ack)", rw); end
    checks++; if (ad !== 24'h000041 || g !== 1 || rd !== 16'h0002) begin
      failures++; $display("FAIL b2b_second got=%h/port%0d/%h exp=000041/port1/0002", ad, g, rd);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req !== 1'b0 || p_ack !== 3'b000) extra++;
      tick();
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_no_duplicate got=%0d exp=0", extra); end
  endtask

  task automatic test_early_done();
    int g, rw, st; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    do_reset();
    set_port(1, 1'b0, 24'h000555, 16'h0, 2'b11);
    p_req = 3'b010;
    serve(0, 2, 16'h5A5A, 1'b1, g, rd, ad, we, wd, be, rw, rag, st, aa);
    p_req = '0;
    checks++; if (st !== 0) begin failures++; $display("FAIL early_done_stray got=%0d exp=0", st); end
    checks++; if (g !== 1 || rd !== 16'h5A5A) begin failures++; $display("FAIL early_done_data got=port%0d/%h exp=port1/5a5a", g, rd); end
  endtask

  task automatic test_watchdog();
    int n, g, rw, st; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    do_reset();
    set_port(1, 1'b0, 24'h000777, 16'h0, 2'b11);
    p_req = 3'b010;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL wd_req got=%b exp=1", mem_req); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n = 0;
    while (p_ack === 3'b000 && n < 300) begin tick(); n++; end
    $display("txn port=%0d addr=000777 aborted rdata=%h", ack_port(p_ack), p_rdata);
    checks++; if (n !== 255) begin failures++; $display("FAIL wd_abort_cycles got=%0d exp=255", n); end
    checks++; if (p_ack !== 3'b010) begin failures++; $display("FAIL wd_p_ack got=%b exp=010", p_ack); end
    checks++; if (p_rdata !== 16'hFFFF) begin failures++; $display("FAIL wd_p_rdata got=%h exp=ffff", p_rdata); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL wd_timeout_err got=%b exp=1", timeout_err); end
    tick();
    p_req = '0;
    repeat (5) tick();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wd_sticky got=err%b/busy%b exp=err1/busy0", timeout_err, busy); end
    p_req = 3'b010;
    serve(0, 1, 16'h1234, 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
    p_req = '0;
    checks++; if (g !== 1 || rd !== 16'h1234 || timeout_err !== 1'b1) begin
      failures++; $display("FAIL wd_after_txn got=port%0d/%h/err%b exp=port1/1234/err1", g, rd, timeout_err);
    end
    do_reset();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_reset_clear got=%b exp=0", timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    int n, seen; int g, rw, st; logic [15:0] rd, wd; logic [23:0] ad; logic we, rag; logic [1:0] be; logic [2:0] aa;
    do_reset();
    set_port(2, 1'b0, 24'h000222, 16'h0, 2'b11);
    p_req = 3'b100;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin tick(); n++; end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmw_busy_in_wait got=%b exp=1", busy); end
    reset = 1'b1; p_req = '0;
    tick();
    reset = 1'b0;
    checks++; if ({mem_req, busy, p_ack} !== 5'b0) begin
      failures++; $display("FAIL rmw_after_reset got=req%b/busy%b/ack%b exp=req0/busy0/ack000", mem_req, busy, p_ack);
    end
    mem_done = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (p_ack !== 3'b000 || busy !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmw_late_done_ignored got=%0d exp=0", seen); end
    p_req = 3'b100;
    serve(1, 1, 16'h0F0F, 1'b0, g, rd, ad, we, wd, be, rw, rag, st, aa);
    p_req = '0;
    checks++; if (g !== 2 || rd !== 16'h0F0F || ad !== 24'h000222) begin
      failures++; $display("FAIL rmw_next_txn got=port%0d/%h/%h exp=port2/0f0f/000222", g, rd, ad);
    end
  endtask

  initial begin
    reset = 1'b1; p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0; p_be = '0;
    mem_gnt = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    tick();
    test_reset();
    test_single_read();
    test_priority();
    test_byte_write();
    test_back_to_back();
    test_early_done();
    test_watchdog();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
